y86_fetch_seq: RTL and testbench
================================

Name: y86_fetch_seq

Overview:
- Multi-cycle byte-serial instruction fetch for the Y86-64 core.
- Reads one instruction starting at a given PC from byte-wide instruction memory through a req/ack handshake, then decodes the fields.
- Presents icode, ifun, rA, rB, valC, valP, instr_valid and imem_error to the decode/PC-update path and to the status unit (HLT/ADR/INS/AOK).
- Sits directly upstream of the status unit; its icode, instr_valid and imem_error outputs feed it.

Parameters:
- ADDR_W, 64, PC and memory address width.
- MEM_BYTES, 8192, instruction memory size in bytes; any byte address >= MEM_BYTES is an error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  start a fetch; accepted only in IDLE.
- fetch_pc  in  ADDR_W  PC of the instruction; sampled when fetch_req is accepted.
- busy  out  1  high in every state except IDLE.
- mem_req  out  1  byte read request; held until mem_ack or mem_err.
- mem_addr  out  ADDR_W  byte address; stable while mem_req is high.
- mem_rdata  in  8  read byte; valid with mem_ack.
- mem_ack  in  1  read completes this cycle.
- mem_err  in  1  read failed this cycle; takes priority over mem_ack.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- icode  out  4  instruction code.
- ifun  out  4  function code.
- rA  out  4  register A; 0xF when absent.
- rB  out  4  register B; 0xF when absent.
- valC  out  64  constant, little-endian assembled; 0 when absent.
- valP  out  ADDR_W  fetch_pc plus instruction length, wraps modulo 2^ADDR_W.
- instr_valid  out  1  0 means illegal icode/ifun.
- imem_error  out  1  memory or bounds error during this fetch.

Behaviour:
- Reset values (asynchronous, active-low):
  - state = IDLE; out_valid = 0; mem_req = 0; mem_addr = 0; busy = 0.
  - icode = 4'h1 (nop, so the status unit does not see HLT at reset); ifun = 0; rA = rB = 4'hF; valC = 0; valP = 0.
  - instr_valid = 1; imem_error = 0.
- States: IDLE -> OPB -> (REGB) -> (CONST x8) -> DONE -> IDLE.
- IDLE, fetch_req accepted: latch fetch_pc into pc_base, clear error flags and valC, go to OPB.
- OPB: read byte at pc_base; icode = byte[7:4], ifun = byte[3:0].
- Legality:
  - icode 2 and 7: ifun 0..6 legal.
  - icode 6: ifun 0..3 legal.
  - icode 0,1,3,4,5,8,9,A,B: ifun must be 0.
  - icode C..F: illegal.
- Illegal instruction: instr_valid = 0, valP = pc_base + 1, go to DONE.
- Lengths:
  - 1 byte: 0, 1, 9.
  - 2 bytes (REGB): 2, 6, A, B.
  - 10 bytes (REGB + CONST): 3, 4, 5.
  - 9 bytes (CONST only): 7, 8.
- REGB: rA = byte[7:4], rB = byte[3:0]. No check on register values.
- CONST: 3-bit beat counter k = 0..7; byte k goes to valC[8k+7:8k]. Leave CONST after k = 7 is acknowledged.
- Bounds check: before raising mem_req for address a, if a >= MEM_BYTES, or the address wrapped past 2^ADDR_W, then:
  - set imem_error = 1 and do not issue the request;
  - go to DONE on the next cycle.
- mem_err on any beat: imem_error = 1, go to DONE, fields hold whatever was captured so far.
- mem_err together with mem_ack: error wins.
- Read latency:
  - One cycle minimum from mem_req high to a state advance on mem_ack.
  - Each beat raises mem_req on the cycle after the previous ack; there is no combinational req->ack path.
  - Total cycles = instruction length + 1 (DONE) when memory acks in zero wait states.
- DONE: out_valid = 1, all outputs stable. On out_valid && out_ready, return to IDLE and drop out_valid in the next cycle.
- fetch_req asserted outside IDLE is ignored; no queuing.
- Reset mid-fetch aborts immediately: mem_req drops asynchronously and all outputs return to reset values.

Optional Feature:
- Macro: Y86_FETCH_CNT_EN.
- Defined:
  - adds output fetch_count [31:0], reset 0;
  - increments on each DONE handshake with instr_valid && !imem_error;
  - saturates at 32'hFFFF_FFFF.
- Undefined: no port and no counter logic; behaviour otherwise identical.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT..IPOPQ = 0..B.
  - RNONE = 4'hF.
  - Fetch state enum: IDLE, OPB, REGB, CONST, DONE.
  - Length function len_of(icode): returns 1, 2, 9 or 10.
  - Legality function legal(icode, ifun).
- Sub-module y86_instr_len_chk: combinational legality and length from (icode, ifun); used in OPB.

Test Plan:
- Zero-wait memory, pc = 0x10, bytes 30 F3 08 07 06 05 04 03 02 01 (irmovq) -> after 11 cycles:
  - out_valid = 1, icode = 3, rA = F, rB = 3;
  - valC = 0x0102030405060708, valP = 0x1A, instr_valid = 1.
- Byte 00 at pc 0x0 -> DONE after 2 cycles with icode = 0, valP = 0x1, no further mem_req.
- Byte 65 (ifun 5 on icode 6) -> instr_valid = 0, valP = pc + 1, exactly one mem_req beat.
- pc = 8190 with jXX 70 -> bytes 8190 and 8191 read, address 8192 is never requested, imem_error = 1, out_valid = 1.
- mem_err on beat 3 of mrmovq with 2 wait states per beat -> imem_error = 1, DONE. Then hold out_ready = 0 for 5 cycles -> outputs stable, busy = 1, and a fetch_req in that window is ignored.
- rst_n pulsed low mid-CONST:
  - mem_req = 0 and icode = 1 immediately;
  - the next fetch at 0x0 decodes correctly.
  - With Y86_FETCH_CNT_EN, fetch_count = 0 after reset.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 fetch constants, state encoding and decode helpers
//   icode constants IHALT..IPOPQ, RNONE, fetch_state_t,
//   len_of(icode) -> instruction length in bytes, legal(icode, ifun) -> legality
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;
   localparam logic [3:0] RNONE   = 4'hF;

   typedef enum logic [2:0] {IDLE, OPB, REGB, CONST, DONE} fetch_state_t;

   function automatic logic [3:0] len_of(input logic [3:0] icode);
      case (icode)
         IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: return 4'd2;
         IIRMOVQ, IRMMOVQ, IMRMOVQ:    return 4'd10;
         IJXX, ICALL:                  return 4'd9;
         default:                      return 4'd1;
      endcase
   endfunction

   function automatic logic legal(input logic [3:0] icode, input logic [3:0] ifun);
      case (icode)
         IRRMOVQ, IJXX: return ifun <= 4'd6;
         IOPQ:          return ifun <= 4'd3;
         IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ:
                        return ifun == 4'd0;
         default:       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/y86_instr_len_chk.sv
// y86_instr_len_chk: combinational legality and length of an opcode byte
//   icode, ifun in  : fields of the opcode byte
//   ok          out : icode/ifun pair is a legal instruction
//   len         out : instruction length in bytes (1, 2, 9 or 10)
module y86_instr_len_chk
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   input  logic [3:0] ifun,
   output logic       ok,
   output logic [3:0] len
);

   assign ok  = legal(icode, ifun);
   assign len = len_of(icode);

endmodule

// File: rtl/y86_fetch_seq.sv
// y86_fetch_seq: byte-serial Y86-64 instruction fetch over a req/ack byte memory
//   clk, rst_n            : clock, asynchronous active-low reset
//   fetch_req, fetch_pc   : start a fetch at fetch_pc (accepted only when idle)
//   busy                  : fetch in progress or result pending
//   mem_req/addr/rdata/ack/err : byte-wide instruction memory handshake
//   out_valid, out_ready  : decoded result handshake
//   icode ifun rA rB valC valP instr_valid imem_error : decoded fields and status
//   fetch_count           : good-instruction counter, only with Y86_FETCH_CNT_EN
module y86_fetch_seq
   import y86_pkg::*;
#(
   parameter int          ADDR_W    = 64,
   parameter int unsigned MEM_BYTES = 8192
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_pc,
   output logic              busy,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack,
   input  logic              mem_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        icode,
   output logic [3:0]        ifun,
   output logic [3:0]        rA,
   output logic [3:0]        rB,
   output logic [63:0]       valC,
   output logic [ADDR_W-1:0] valP,
   output logic              instr_valid,
   output logic              imem_error
`ifdef Y86_FETCH_CNT_EN
   ,
   output logic [31:0]       fetch_count
`endif
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc_base;
   logic [2:0]        k;
   logic [ADDR_W:0]   nxt;
   logic              nxt_bad, pc_bad, ok;
   logic [3:0]        len;

   y86_instr_len_chk u_chk (.icode(mem_rdata[7:4]), .ifun(mem_rdata[3:0]), .ok(ok), .len(len));

   // Next byte address with carry so a wrap past 2^ADDR_W counts as out of range.
   assign nxt     = {1'b0, mem_addr} + 1'b1;
   assign nxt_bad = nxt[ADDR_W] || nxt[ADDR_W-1:0] >= ADDR_W'(MEM_BYTES);
   assign pc_bad  = fetch_pc >= ADDR_W'(MEM_BYTES);
   assign busy      = state != IDLE;
   assign out_valid = state == DONE;

   // mem_req stays high across back-to-back beats; mem_addr steps on each ack.
   // An out-of-range next address finishes the fetch instead of requesting it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         pc_base     <= '0;
         k           <= '0;
         icode       <= INOP;
         ifun        <= '0;
         rA          <= RNONE;
         rB          <= RNONE;
         valC        <= '0;
         valP        <= '0;
         instr_valid <= 1'b1;
         imem_error  <= 1'b0;
`ifdef Y86_FETCH_CNT_EN
         fetch_count <= '0;
`endif
      end else if (mem_req && mem_err) begin
         imem_error <= 1'b1;
         mem_req    <= 1'b0;
         state      <= DONE;
      end else begin
         case (state)
            IDLE: if (fetch_req) begin
               pc_base     <= fetch_pc;
               mem_addr    <= fetch_pc;
               k           <= '0;
               valC        <= '0;
               rA          <= RNONE;
               rB          <= RNONE;
               instr_valid <= 1'b1;
               imem_error  <= pc_bad;
               mem_req     <= !pc_bad;
               state       <= pc_bad ? DONE : OPB;
            end
            OPB: if (mem_ack) begin
               icode       <= mem_rdata[7:4];
               ifun        <= mem_rdata[3:0];
               instr_valid <= ok;
               valP        <= pc_base + ADDR_W'(ok ? len : 4'd1);
               // Finishing a legal multi-byte instruction here means the next address is bad.
               if (!ok || len == 4'd1 || nxt_bad) begin
                  imem_error <= ok && len != 4'd1;
                  mem_req    <= 1'b0;
                  state      <= DONE;
               end else begin
                  mem_addr <= nxt[ADDR_W-1:0];
                  state    <= (len == 4'd9) ? CONST : REGB;
               end
            end
            REGB: if (mem_ack) begin
               rA <= mem_rdata[7:4];
               rB <= mem_rdata[3:0];
               if (len_of(icode) == 4'd2 || nxt_bad) begin
                  imem_error <= len_of(icode) != 4'd2;
                  mem_req    <= 1'b0;
                  state      <= DONE;
               end else begin
                  mem_addr <= nxt[ADDR_W-1:0];
                  state    <= CONST;
               end
            end
            CONST: if (mem_ack) begin
               valC[{k, 3'b000} +: 8] <= mem_rdata;
               if (k == 3'd7 || nxt_bad) begin
                  imem_error <= k != 3'd7;
                  mem_req    <= 1'b0;
                  state      <= DONE;
               end else begin
                  mem_addr <= nxt[ADDR_W-1:0];
                  k        <= k + 3'd1;
               end
            end
            DONE: if (out_ready) begin
               state <= IDLE;
`ifdef Y86_FETCH_CNT_EN
               if (instr_valid && !imem_error && fetch_count != '1)
                  fetch_count <= fetch_count + 32'd1;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_y86_fetch_seq.sv
// tb_y86_fetch_seq: randomized self-checking bench for y86_fetch_seq against a byte-level fetch model
module tb_y86_fetch_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_req = 1'b0;
   logic [63:0] fetch_pc = '0;
   logic        busy, mem_req, mem_ack, mem_err, out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] mem_addr, valC, valP;
   logic [7:0]  mem_rdata;
   logic [3:0]  icode, ifun, rA, rB;
   logic        instr_valid, imem_error;
`ifdef Y86_FETCH_CNT_EN
   logic [31:0] fetch_count;
`endif

   y86_fetch_seq dut (
      .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .busy(busy),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_err(mem_err), .out_valid(out_valid), .out_ready(out_ready), .icode(icode),
      .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP), .instr_valid(instr_valid),
      .imem_error(imem_error)
`ifdef Y86_FETCH_CNT_EN
      , .fetch_count(fetch_count)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:8191];
   int   wait_n = 0, err_beat = -1, wcnt = 0, beat_no = 0;
   logic hit, bad_req = 1'b0;

   // Memory: ack after wait_n idle cycles per beat, error injected on beat err_beat.
   assign hit       = mem_req && wcnt == wait_n;
   assign mem_ack   = hit;
   assign mem_err   = hit && beat_no == err_beat;
   assign mem_rdata = mem[mem_addr[12:0]];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) wcnt <= 0;
      else begin
         wcnt <= (mem_req && !hit) ? wcnt + 1 : 0;
         if (fetch_req && !busy) beat_no <= 0;
         else if (hit) beat_no <= beat_no + 1;
         if (mem_req && mem_addr >= 64'd8192) bad_req <= 1'b1;
      end
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model: walk the instruction byte by byte from the opcode tables.
   int maxf [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
   int lens [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
   logic [3:0]  e_icode = 4'h1, e_ifun = 4'h0, e_ra, e_rb;
   logic [63:0] e_valc, e_valp = '0;
   logic        e_valid, e_err;
   int          e_beats, e_cnt = 0;

   task automatic model(input logic [63:0] pc, input int eb);
      logic [7:0]  b;
      logic [63:0] a;
      int          n;
      e_err = 1'b0; e_valid = 1'b1; e_ra = 4'hF; e_rb = 4'hF; e_valc = '0; e_beats = 0;
      if (pc >= 64'd8192) begin e_err = 1'b1; return; end
      e_beats = 1;
      if (eb == 0) begin e_err = 1'b1; return; end
      b = mem[pc[12:0]];
      e_icode = b[7:4];
      e_ifun  = b[3:0];
      e_valid = int'(e_ifun) <= maxf[e_icode];
      n = e_valid ? lens[e_icode] : 1;
      e_valp = pc + 64'(n);
      for (int i = 1; i < n; i++) begin
         a = pc + 64'(i);
         if (a >= 64'd8192) begin e_err = 1'b1; return; end
         e_beats++;
         if (eb == i) begin e_err = 1'b1; return; end
         b = mem[a[12:0]];
         if (i == 1 && n != 9) begin e_ra = b[7:4]; e_rb = b[3:0]; end
         else e_valc[8*(i - (n == 9 ? 1 : 2)) +: 8] = b;
      end
   endtask

   task automatic run(input logic [63:0] pc, input int ws, input int eb, input int hold);
      int cyc = 0;
      model(pc, eb);
      wait_n = ws;
      err_beat = eb;
      fetch_pc = pc;
      fetch_req = 1'b1;
      do begin
         @(negedge clk);
         fetch_req = 1'b0;
         cyc++;
      end while (!out_valid && cyc < 300);
      chk("cycles", 64'(cyc), 64'(e_beats * (ws + 1) + 1));
      chk("out_valid", out_valid, 1);
      chk("icode", icode, e_icode);
      chk("ifun", ifun, e_ifun);
      chk("rA", rA, e_ra);
      chk("rB", rB, e_rb);
      chk("valC", valC, e_valc);
      chk("valP", valP, e_valp);
      chk("instr_valid", instr_valid, e_valid);
      chk("imem_error", imem_error, e_err);
      chk("beats", 64'(beat_no), 64'(e_beats));
      repeat (hold) begin
         fetch_req = 1'b1;
         fetch_pc = 64'h0;
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_busy", busy, 1);
         chk("hold_req", mem_req, 0);
         chk("hold_icode", icode, e_icode);
         chk("hold_valC", valC, e_valc);
      end
      fetch_req = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      if (e_valid && !e_err) e_cnt++;
      chk("drop_valid", out_valid, 0);
      chk("idle", busy, 0);
`ifdef Y86_FETCH_CNT_EN
      chk("fetch_count", fetch_count, 64'(e_cnt));
`endif
   endtask

   task automatic chk_reset();
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_icode", icode, 4'h1);
      chk("rst_ifun", ifun, 0);
      chk("rst_rA", rA, 4'hF);
      chk("rst_rB", rB, 4'hF);
      chk("rst_valC", valC, 0);
      chk("rst_valP", valP, 0);
      chk("rst_ivalid", instr_valid, 1);
      chk("rst_err", imem_error, 0);
`ifdef Y86_FETCH_CNT_EN
      chk("rst_count", fetch_count, 0);
`endif
   endtask

   initial begin
      logic [63:0] pc;
      int r;
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      repeat (2) @(negedge clk);
      chk_reset();
      rst_n = 1'b1;
      @(negedge clk);
      // irmovq $0x0102030405060708, %rbx at 0x10
      mem[16'h10] = 8'h30;
      mem[16'h11] = 8'hF3;
      for (int i = 0; i < 8; i++) mem[16'h12 + i] = 8'(8 - i);
      run(64'h10, 0, -1, 0);
      chk("irmov_valC", valC, 64'h0102030405060708);
      chk("irmov_valP", valP, 64'h1A);
      chk("irmov_rB", rB, 4'h3);
      // halt at 0
      mem[0] = 8'h00;
      run(64'h0, 0, -1, 0);
      chk("halt_valP", valP, 64'h1);
      // OPq with illegal ifun 5
      mem[16'h20] = 8'h65;
      run(64'h20, 0, -1, 0);
      // jXX straddling the end of memory
      mem[8190] = 8'h70;
      run(64'd8190, 0, -1, 0);
      // mrmovq with memory error on its fourth beat, two wait states, then a stalled consumer
      mem[16'h30] = 8'h50;
      mem[16'h31] = 8'h12;
      run(64'h30, 2, 3, 5);
      // reset in the middle of the constant bytes
      wait_n = 1;
      err_beat = -1;
      fetch_pc = 64'h10;
      fetch_req = 1'b1;
      @(negedge clk);
      fetch_req = 1'b0;
      repeat (8) @(negedge clk);
      chk("mid_const_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 chk_reset();
      @(negedge clk);
      rst_n = 1'b1;
      e_icode = 4'h1; e_ifun = 4'h0; e_valp = '0; e_cnt = 0;
      run(64'h0, 0, -1, 0);
      // randomized fetches, including out-of-range and wrapping PCs
      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(0, 9);
         pc = r == 0 ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)) :
              r == 1 ? 64'd8192 + 64'($urandom_range(0, 100)) :
              r <= 3 ? 64'd8180 + 64'($urandom_range(0, 11)) : 64'($urandom_range(0, 8191));
         if (pc < 64'd8192) mem[pc[12:0]] = {4'($urandom_range(0, 12)), 4'($urandom_range(0, 6))};
         run(pc, $urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1,
             $urandom_range(0, 2));
      end
      chk("no_oob_req", bad_req, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
